serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the one-bit `fulladder` cell from combckts.
- Captures two operands and a carry-in on `start`, then feeds one bit pair per clock, LSB first, through a single `fulladder` instance, with the carry held in a flop.
- Presents the registered sum and carry-out with a one-cycle `done` pulse.
- Sits directly upstream of, and wraps, the existing `fulladder`. It is the sequential stage that drives that cell and consumes its outputs.

Parameters:
- W, 8, operand/sum width in bits; legal range W >= 1.
- CW, derived as $clog2(W+1); width of the bit counter; not for override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin an addition; sampled only when busy=0
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- cin  input  1  carry-in; sampled with start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; sum/cout valid and new
- sum  output  W  registered result; holds until the next completion
- cout  output  1  registered final carry; holds with sum
- ovf  output  1  signed overflow; present only with the optional feature

Behaviour:
- Reset (asynchronous, rst_n=0) forces the following immediately:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0, ovf=0
  - internal shift registers, carry flop and counter cleared
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - start=1 at edge k loads a_sr<=a, b_sr<=b, carry<=cin, cnt<=0; next state SHIFT.
  - busy=1 from edge k.
  - start=0 stays in IDLE.
- SHIFT, at each edge:
  - fulladder inputs are a_sr[0], b_sr[0], carry.
  - Its s bit enters s_sr at the MSB (shift right); a_sr and b_sr shift right; carry<=c; cnt<=cnt+1.
- Completion: the edge at which cnt==W-1 performs the last shift (edge k+W) and also:
  - sum<=final s_sr, cout<=final c
  - done<=1, busy<=0, state<=IDLE
- Latency: done is high during the cycle after edge k+W, i.e. exactly W clocks after start is sampled.
- done is high for exactly one cycle and is cleared at the next edge.
- start while busy=1 is ignored; operands are not re-sampled.
- start in the done cycle (state already IDLE) is accepted. Back-to-back throughput is one result per W+1... precisely: the next start is sampled at edge k+W+1, giving done at k+2W+1.
- sum/cout are not cleared by start; they change only at completion or reset.
- Reset mid-operation:
  - the operation is abandoned and no done is produced
  - sum/cout return to 0
- W=1: the single shift completes at edge k+1; the state machine is otherwise unchanged.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(W+1). No truncation beyond W+1 bits.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN
- Defined:
  - The ovf port exists.
  - At completion, ovf<=(carry into MSB) XOR (carry out of MSB). This equals the signed two's-complement overflow of a+b+cin.
  - ovf holds with sum, resets to 0, and is updated only at completion.
- Not defined: the ovf port and its logic are absent; the port list ends at cout.

Decomposition:
- Shared header/package serial_adder_pkg holds:
  - state encodings (IDLE=1'b0, SHIFT=1'b1)
  - default W
- Sub-module: the existing fulladder (ports a, b, cin, s, c), instantiated once as the bit-slice datapath. No new sub-module is written.

Test Plan:
- W=8, a=8'h35, b=8'h4A, cin=0, start one cycle -> busy high for 8 cycles; done pulse 8 clocks after start; sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start held high throughout, with a/b changed mid-operation -> the first result uses the captured operands only. A second start is accepted in the done cycle, and its done follows exactly 8 clocks later.
- rst_n pulled low at shift cycle 4 -> busy, done, sum and cout are 0 immediately; no done pulse follows. A fresh start after reset gives a correct result.
- W=1, all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table; done arrives 1 clock after start.
- With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 -> ovf=1; a=8'h80, b=8'hFF -> ovf=1, cout=1; a=8'h35, b=8'h4A -> ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int W_DEFAULT = 8;

endpackage

// File: rtl/fulladder.sv
// Existing one-bit full adder cell (combckts); used as the serial adder's bit slice.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one fulladder slice, LSB first, result registered after W clocks.
// Defining SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_r;
  logic [W-1:0]  a_sr_r;
  logic [W-1:0]  b_sr_r;
  logic [W-1:0]  s_sr_r;
  logic [W-1:0]  s_sr_next_s;
  logic          carry_r;
  logic [CW-1:0] cnt_r;
  logic          fa_s_s;
  logic          fa_c_s;

  fulladder u_fa (
    .a   (a_sr_r[0]),
    .b   (b_sr_r[0]),
    .cin (carry_r),
    .s   (fa_s_s),
    .c   (fa_c_s)
  );

  // New sum bit enters at the MSB so that after W shifts bit 0 holds the first result.
  generate
    if (W == 1) begin : g_w1
      assign s_sr_next_s = fa_s_s;
    end else begin : g_wn
      assign s_sr_next_s = {fa_s_s, s_sr_r[W-1:1]};
    end
  endgenerate

  // Control FSM and datapath registers, including the registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      s_sr_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            carry_r <= cin;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_r  <= a_sr_r >> 1'b1;
          b_sr_r  <= b_sr_r >> 1'b1;
          s_sr_r  <= s_sr_next_s;
          carry_r <= fa_c_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            sum     <= s_sr_next_s;
            cout    <= fa_c_s;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_r is the carry into the MSB slice on this final shift.
            ovf     <= carry_r ^ fa_c_s;
`endif
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy    <= 1'b1;
            state_r <= SHIFT;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (W=8 and W=1 instances) with an expected-result scoreboard.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1, ovf1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];
  logic [1:0] exp1_q[$];

  always #5 clk = ~clk;

  serial_adder #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic start_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + {8'h00, tc});
  endtask

  // Counts negedges from the start drive until done; -1 if the bound expires.
  task automatic wait_done8(input bit hold, input int skip, output int lat, output int blo);
    lat = -1; blo = 0;
    for (int i = skip + 1; i <= skip + 40; i++) begin
      @(negedge clk);
      if (!hold) start8 = 1'b0;
      if (done8) begin lat = i; break; end
      if (!busy8) blo++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #12;
    n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done8); end
    n_cmp++; if (sum8 !== 8'h00) begin n_bad++; $display("FAIL reset_sum: got %h want 00", sum8); end
    n_cmp++; if (cout8 !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", cout8); end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++; if (ovf8 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf8); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [7:0] ta [3] = '{8'h35, 8'hFF, 8'hFF};
    logic [7:0] tb [3] = '{8'h4A, 8'h01, 8'hFF};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    int lat, blo;
    logic [8:0] exp;
    for (int t = 0; t < 3; t++) begin
      start_op8(ta[t], tb[t], tc[t]);
      wait_done8(1'b0, 0, lat, blo);
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL add_latency[%0d]: got %0d want 9", t, lat); end
      n_cmp++; if (blo !== 0) begin n_bad++; $display("FAIL add_busy[%0d]: busy low %0d cycles want 0", t, blo); end
      exp = exp_q.pop_front();
      n_cmp++; if ({cout8, sum8} !== exp) begin n_bad++; $display("FAIL add_result[%0d]: got %h want %h", t, {cout8, sum8}, exp); end
      @(negedge clk);
      n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL done_width[%0d]: got %b want 0", t, done8); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, blo;
    logic [8:0] exp;
    start_op8(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b0;
    wait_done8(1'b1, 2, lat, blo);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL b2b_latency1: got %0d want 9", lat); end
    exp_q.push_back({1'b0, a8} + {1'b0, b8} + {8'h00, cin8});
    exp = exp_q.pop_front();
    n_cmp++; if ({cout8, sum8} !== exp) begin n_bad++; $display("FAIL b2b_result1: got %h want %h", {cout8, sum8}, exp); end
    wait_done8(1'b0, 0, lat, blo);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 9", lat); end
    exp = exp_q.pop_front();
    n_cmp++; if ({cout8, sum8} !== exp) begin n_bad++; $display("FAIL b2b_result2: got %h want %h", {cout8, sum8}, exp); end
  endtask

  task automatic test_reset_mid();
    int lat, blo, seen;
    logic [8:0] exp;
    start_op8(8'h81, 8'h02, 1'b1);
    for (int i = 0; i < 4; i++) begin @(negedge clk); start8 = 1'b0; end
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_done: got %b want 0", done8); end
    n_cmp++; if (sum8 !== 8'h00) begin n_bad++; $display("FAIL mid_reset_sum: got %h want 00", sum8); end
    n_cmp++; if (cout8 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_cout: got %b want 0", cout8); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done8) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", seen); end
    start_op8(8'h81, 8'h02, 1'b1);
    wait_done8(1'b0, 0, lat, blo);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL post_reset_latency: got %0d want 9", lat); end
    exp = exp_q.pop_front();
    n_cmp++; if ({cout8, sum8} !== exp) begin n_bad++; $display("FAIL post_reset_result: got %h want %h", {cout8, sum8}, exp); end
  endtask

  task automatic test_w1();
    int lat;
    logic [1:0] exp;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1'b1;
      exp1_q.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (done1) begin lat = i; break; end
      end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL w1_latency[%0d]: got %0d want 2", v, lat); end
      exp = exp1_q.pop_front();
      n_cmp++; if ({cout1, sum1} !== exp) begin n_bad++; $display("FAIL w1_result[%0d]: got %b want %b", v, {cout1, sum1}, exp); end
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] ta [3] = '{8'h7F, 8'h80, 8'h35};
    logic [7:0] tb [3] = '{8'h01, 8'hFF, 8'h4A};
    int lat, blo, ssum;
    logic exp_ovf;
    logic [8:0] exp;
    for (int t = 0; t < 3; t++) begin
      ssum = int'($signed(ta[t])) + int'($signed(tb[t]));
      exp_ovf = (ssum > 127) || (ssum < -128);
      start_op8(ta[t], tb[t], 1'b0);
      wait_done8(1'b0, 0, lat, blo);
      exp = exp_q.pop_front();
      n_cmp++; if ({cout8, sum8} !== exp) begin n_bad++; $display("FAIL ovf_result[%0d]: got %h want %h", t, {cout8, sum8}, exp); end
      n_cmp++; if (ovf8 !== exp_ovf) begin n_bad++; $display("FAIL ovf_flag[%0d]: got %b want %b", t, ovf8, exp_ovf); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_reset_mid();
    test_w1();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
